// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: maps PS/2 key events and joysticks to registered per-player
// arcade controls, with SOCD cleaning, cocktail mirroring and a stretched coin pulse.
module arcade_input_mapper #(
  parameter int          NUM_PLAYERS  = 2,
  parameter logic [15:0] COIN_PULSE   = 16'd50000,
  parameter bit          SOCD_NEUTRAL = 1'b1
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [10:0]              ps2_key,
  input  logic [16*NUM_PLAYERS-1:0] joystick,
  input  logic                     cocktail,
  input  logic                     auto_coin,
  output logic [NUM_PLAYERS-1:0]   p_right,
  output logic [NUM_PLAYERS-1:0]   p_left,
  output logic [NUM_PLAYERS-1:0]   p_down,
  output logic [NUM_PLAYERS-1:0]   p_up,
  output logic [NUM_PLAYERS-1:0]   p_fire,
  output logic [NUM_PLAYERS-1:0]   p_start,
  output logic                     coin
);
  logic                          toggle_q, toggle_d, prime_q, prime_d;
  logic [1:0][4:0]               kp_q, kp_d;
  logic [1:0]                    ks_q, ks_d, kc_q, kc_d;
  logic [15:0]                   cnt_q, cnt_d;
  logic                          coin_q, coin_d;
  logic [NUM_PLAYERS-1:0][5:0]   ctl_q, ctl_d, res;
  logic [3:0][5:0]               key_pl;
  logic                          ev, coin_req, unused_jbits;
  assign unused_jbits = ^joystick;
  assign ev = prime_q && (ps2_key[10] != toggle_q);
  always_comb begin
    kp_d = kp_q;
    ks_d = ks_q;
    kc_d = kc_q;
    if (ev) begin
      case (ps2_key[8:0])
        9'h175:         kp_d[0][3] = ps2_key[9];
        9'h172:         kp_d[0][2] = ps2_key[9];
        9'h16B:         kp_d[0][1] = ps2_key[9];
        9'h174:         kp_d[0][0] = ps2_key[9];
        9'h029, 9'h014: kp_d[0][4] = ps2_key[9];
        9'h01D:         kp_d[1][3] = ps2_key[9];
        9'h01C:         kp_d[1][1] = ps2_key[9];
        9'h01B:         kp_d[1][2] = ps2_key[9];
        9'h023:         kp_d[1][0] = ps2_key[9];
        9'h012:         kp_d[1][4] = ps2_key[9];
        9'h005, 9'h016: ks_d[0] = ps2_key[9];
        9'h006, 9'h01E: ks_d[1] = ps2_key[9];
        9'h02E:         kc_d[0] = ps2_key[9];
        9'h036:         kc_d[1] = ps2_key[9];
        default: ;
      endcase
    end
  end
  always_comb begin
    key_pl = '0;
    key_pl[0] = {ks_q[0], kp_q[0]};
    key_pl[1] = {ks_q[1], kp_q[1]};
    res = '0;
    ctl_d = '0;
    coin_req = |kc_q;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      res[p] = joystick[16*p +: 6] | key_pl[p];
      if (SOCD_NEUTRAL && res[p][0] && res[p][1]) res[p][1:0] = 2'b00;
      if (SOCD_NEUTRAL && res[p][2] && res[p][3]) res[p][3:2] = 2'b00;
      coin_req = coin_req | joystick[16*p+6] | (auto_coin & res[p][5]);
      ctl_d[p] = res[p];
      // player 2 follows player 1 on an upright cabinet; start stays independent
      if (p == 1 && !cocktail) ctl_d[p][4:0] = res[0][4:0];
    end
    cnt_d = coin_req ? COIN_PULSE : (cnt_q != 16'd0 ? cnt_q - 16'd1 : 16'd0);
    coin_d = cnt_d != 16'd0;
    toggle_d = ps2_key[10];
    prime_d = 1'b1;
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= 1'b0;
      prime_q <= 1'b0;
      kp_q <= '0;
      ks_q <= '0;
      kc_q <= '0;
      cnt_q <= '0;
      coin_q <= 1'b0;
      ctl_q <= '0;
    end else begin
      toggle_q <= toggle_d;
      prime_q <= prime_d;
      kp_q <= kp_d;
      ks_q <= ks_d;
      kc_q <= kc_d;
      cnt_q <= cnt_d;
      coin_q <= coin_d;
      ctl_q <= ctl_d;
    end
  end
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      p_right[p] = ctl_q[p][0];
      p_left[p] = ctl_q[p][1];
      p_down[p] = ctl_q[p][2];
      p_up[p] = ctl_q[p][3];
      p_fire[p] = ctl_q[p][4];
      p_start[p] = ctl_q[p][5];
    end
  end
  assign coin = coin_q;
endmodule

// File: doc/arcade_input_mapper.md
ARCADE_INPUT_MAPPER -- requirements
Module: arcade_input_mapper

Interface
REQ-001 Parameter NUM_PLAYERS, default 2: number of player channels, legal range 1..4.
REQ-002 Parameter COIN_PULSE, default 16'd50000: coin output hold time in clk_sys cycles after the last coin request, legal range 1..65535.
REQ-003 Parameter SOCD_NEUTRAL, default 1: when 1, opposing directions pressed together resolve to neither.
REQ-004 clk_sys  in  1  system clock; all state is on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ps2_key  in  11  keyboard event: [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
REQ-007 joystick  in  16*NUM_PLAYERS  packed per player, player p at [16p+15:16p]: bit0 right, 1 left, 2 down, 3 up, 4 fire, 5 start, 6 coin.
REQ-008 cocktail  in  1  0 = player 2 outputs mirror player 1; 1 = independent player 2.
REQ-009 auto_coin  in  1  1 = any start request also raises a coin request.
REQ-010 p_right, p_left, p_down, p_up, p_fire, p_start  out  NUM_PLAYERS each  registered per-player controls.
REQ-011 coin  out  1  stretched coin pulse.

Function
REQ-012 A keyboard event SHALL be recognised only when ps2_key[10] differs from its value registered on the previous cycle.
REQ-013 The first cycle after reset_n deasserts SHALL register ps2_key[10] without decoding an event.
REQ-014 On an event, key state SHALL be set to ps2_key[9] for these codes ({extended,scancode}):
- P1 up 0x175, down 0x172, left 0x16B, right 0x174;
- P1 fire 0x029 or 0x014, sharing one bit: last event wins;
- P2 up 0x01D (W), left 0x01C (A), down 0x01B (S), right 0x023 (D), fire 0x012 (L-shift);
- start1 0x005 or 0x016, start2 0x006 or 0x01E;
- coin_a 0x02E, coin_b 0x036.
REQ-015 Codes not listed in REQ-014 SHALL leave all key state unchanged.
REQ-016 With NUM_PLAYERS=1, P2 keys SHALL be decoded but have no output effect.
REQ-017 Raw control for player p SHALL be the OR of its key bit (players 0,1 only; zero for players 2,3) and its joystick bit.
REQ-018 With SOCD_NEUTRAL=1, left&right both raw-high SHALL give both low; likewise up&down. Applied per player, before mirroring.
REQ-019 With cocktail=0 and NUM_PLAYERS>=2, player 2 direction and fire outputs SHALL equal player 1's.
REQ-020 Start outputs SHALL never be mirrored.
REQ-021 All p_* outputs SHALL be registered.
REQ-022 Latency: joystick change at cycle t appears at t+1; keyboard event at cycle t appears at t+2.
REQ-023 coin_req SHALL be the OR of: coin_a, coin_b, any joystick bit6, and, when auto_coin=1, any raw start.
REQ-024 A 16-bit counter SHALL load COIN_PULSE on every cycle coin_req=1 and decrement toward 0 otherwise.
REQ-025 The counter SHALL saturate at 0.
REQ-026 coin SHALL be registered and equal (counter != 0).
REQ-027 A held coin_req SHALL keep coin high; coin falls exactly COIN_PULSE cycles after the last coin_req cycle.
REQ-028 A new coin_req during an active pulse SHALL reload the counter (retrigger), never shorten the pulse.
REQ-029 Event recognition and joystick input in the same cycle SHALL both take effect per their latencies.

Reset
REQ-030 While reset_n=0, all key state, the toggle register, the coin counter and all outputs SHALL be 0, and the prime flag SHALL be cleared.
REQ-031 Reset asserted mid-pulse SHALL force coin to 0 immediately (asynchronously) with no residual pulse after release.

Verification
REQ-032 Toggle 0->1 with {1,0x175} -> p_up[0]=1 two cycles later; toggle 1->0 with {0,0x175} -> p_up[0]=0.
REQ-033 Release reset with ps2_key[10]=1 and code 0x029 pressed -> p_fire stays 0; next toggle with {1,0x029} -> p_fire[0]=1.
REQ-034 joystick[0]=1 and joystick[1]=1 on player 0, SOCD_NEUTRAL=1 -> p_right[0]=p_left[0]=0; release bit1 -> p_right[0]=1 after 1 cycle.
REQ-035 COIN_PULSE=4, joystick bit6 high 1 cycle -> coin high for exactly 4 cycles; second request at pulse cycle 3 -> coin high through 4 further cycles.
REQ-036 cocktail=0, joystick player 1 right -> p_right=2'b11; cocktail=1 -> p_right=2'b01; start2 key -> p_start=2'b10, and coin pulses only when auto_coin=1.
